// File: rtl/synth_pkg.sv
// synth_pkg: register map, control/status bit positions and frame mode codes for the output stage
//   ADDR_*   : Avalon-MM word addresses
//   CTRL_*   : bit indices inside CTRL
//   MODE_*   : underrun frame policy (zeros or hold last frame)
//   ST_*     : STATUS flag positions (level occupies [15:0])
//   CLR_*    : CLEAR write bits
package synth_pkg;
   localparam logic [1:0] ADDR_CTRL     = 2'd0;
   localparam logic [1:0] ADDR_STATUS   = 2'd1;
   localparam logic [1:0] ADDR_UNDERRUN = 2'd2;
   localparam logic [1:0] ADDR_CLEAR    = 2'd3;
   localparam int CTRL_EN   = 0;
   localparam int CTRL_MODE = 1;
   localparam logic MODE_ZERO = 1'b0;
   localparam logic MODE_HOLD = 1'b1;
   localparam int ST_EMPTY  = 16;
   localparam int ST_FULL   = 17;
   localparam int ST_OVF    = 18;
   localparam int ST_STDROP = 19;
   localparam int CLR_OVF    = 0;
   localparam int CLR_STDROP = 1;
endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: synchronous sample FIFO with combinational read of the head entry
//   clk, reset      : clock, asynchronous active-high reset
//   wr_data, push   : write port; a push while full is ignored unless a pop happens in the same cycle
//   pop             : advance read pointer; ignored while empty
//   rd_data         : entry at the read pointer
//   level/full/empty: occupancy, level equals DEPTH when full
module sample_fifo #(
   parameter int DATA_W = 24,
   parameter int DEPTH  = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     push,
   input  logic                     pop,
   output logic [DATA_W-1:0]        rd_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic wr, rd;
   assign full    = level == LW'(DEPTH);
   assign empty   = level == '0;
   assign wr      = push && (!full || pop);
   assign rd      = pop && !empty;
   assign rd_data = mem[rd_ptr];
   always_ff @(posedge clk)
      if (wr) mem[wr_ptr] <= wr_data;
   // pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(wr);
         rd_ptr <= rd_ptr + AW'(rd);
         level  <= level + LW'(wr) - LW'(rd);
      end
endmodule

// File: rtl/sample_output_stage.sv
// sample_output_stage: buffers interleaved mixer samples and emits one frame per sample tick to the DAC and an Avalon-ST sink
//   clk, reset          : clock, asynchronous active-high reset
//   i_sample(_valid)    : channel-interleaved sample input, ch0 first
//   o_gen_en            : throttle for the generator pipeline
//   o_dac_frame/_strobe : current frame (ch0 in LSBs) and its one-cycle update pulse
//   aso_*               : Avalon-ST source, one packet of CHANNELS beats per frame
//   avs_*               : Avalon-MM control/status slave, 1-cycle read latency
module sample_output_stage
   import synth_pkg::*;
#(
   parameter int DATA_W    = 24,
   parameter int CHANNELS  = 2,
   parameter int DEPTH     = 64,
   parameter int HEADROOM  = 8,
   parameter int CLK_HZ    = 100_000_000,
   parameter int SAMPLE_HZ = 96_000
) (
   input  logic                                        clk,
   input  logic                                        reset,
   input  logic [DATA_W-1:0]                           i_sample,
   input  logic                                        i_sample_valid,
   output logic                                        o_gen_en,
   output logic [CHANNELS*DATA_W-1:0]                  o_dac_frame,
   output logic                                        o_frame_strobe,
   output logic [31:0]                                 aso_data,
   output logic                                        aso_valid,
   input  logic                                        aso_ready,
   output logic [(CHANNELS > 1 ? $clog2(CHANNELS) : 1)-1:0] aso_channel,
   output logic                                        aso_startofpacket,
   output logic                                        aso_endofpacket,
   input  logic [1:0]                                  avs_address,
   input  logic                                        avs_write,
   input  logic                                        avs_read,
   input  logic [31:0]                                 avs_writedata,
   output logic [31:0]                                 avs_readdata
);
   localparam int DIV   = CLK_HZ / SAMPLE_HZ;
   localparam int CH_W  = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
   localparam int LVL_W = $clog2(DEPTH) + 1;
   localparam int CNT_W = $clog2(DIV);
   localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_POP  = 2'd1;
   localparam logic [1:0] S_LOAD = 2'd2;
   localparam logic [1:0] CTRL_RST = {MODE_ZERO, 1'b1};

   // the drain sequence must finish well inside one tick period
   if (DIV < 2 * CHANNELS + 2) begin : g_bad_div
      $error("sample_output_stage: CLK_HZ/SAMPLE_HZ too small for CHANNELS");
   end

   logic [1:0] ctrl, state;
   logic en, mode, tick, skip, pop, last, go, underrun, hs, pending, full, empty;
   logic active, ovf, stdrop, clr_wr, rd_und, unused_wdata;
   logic [CNT_W-1:0] cnt;
   logic [CH_W-1:0] lane, beat;
   logic [LVL_W-1:0] level, free;
   logic [DATA_W-1:0] rd_data;
   logic [CHANNELS-1:0][DATA_W-1:0] cap, frame, next_frame, st_buf;
   logic [15:0] und;
   logic [31:0] status;

   sample_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk(clk),
      .reset(reset),
      .wr_data(i_sample),
      .push(i_sample_valid),
      .pop(pop),
      .rd_data(rd_data),
      .level(level),
      .full(full),
      .empty(empty)
   );

   assign en       = ctrl[CTRL_EN];
   assign mode     = ctrl[CTRL_MODE];
   assign tick     = cnt == CNT_W'(DIV - 1);
   assign go       = en && level >= LVL_W'(CHANNELS);
   assign underrun = tick && state == S_IDLE && en && !go;
   // an underrun frame still walks through POP so frame timing is tick-locked either way
   assign pop      = state == S_POP && !skip;
   assign last     = state == S_POP && lane == LAST_CH;
   assign free     = LVL_W'(DEPTH) - level;
   assign hs       = active && aso_ready;
   assign pending  = active && !(hs && beat == LAST_CH);
   assign clr_wr   = avs_write && avs_address == ADDR_CLEAR;
   assign rd_und   = avs_read && avs_address == ADDR_UNDERRUN;
   assign unused_wdata = ^avs_writedata[31:2];

   // the last lane comes straight from the FIFO head so the frame lands on the cycle after the final pop
   always_comb begin
      next_frame = cap;
      next_frame[CHANNELS-1] = rd_data;
      if (skip) next_frame = mode == MODE_HOLD ? frame : '0;
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) cnt <= '0;
      else cnt <= tick ? '0 : cnt + CNT_W'(1);

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= S_IDLE;
         lane  <= '0;
         skip  <= 1'b0;
         cap   <= '0;
      end else begin
         state <= state == S_IDLE ? (tick ? S_POP : S_IDLE) : state == S_POP ? (last ? S_LOAD : S_POP) : S_IDLE;
         lane  <= state == S_POP ? lane + CH_W'(1) : '0;
         skip  <= state == S_IDLE && tick ? !go : skip;
         if (state == S_POP) cap[lane] <= rd_data;
      end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         frame          <= '0;
         o_frame_strobe <= 1'b0;
      end else begin
         frame          <= last ? next_frame : frame;
         o_frame_strobe <= last;
      end

   assign o_dac_frame = frame;

   // a new frame always restarts the packet; unfinished beats of the old one are dropped
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         st_buf <= '0;
         beat   <= '0;
         active <= 1'b0;
      end else if (last) begin
         st_buf <= next_frame;
         beat   <= '0;
         active <= 1'b1;
      end else if (hs) begin
         beat   <= beat == LAST_CH ? '0 : beat + CH_W'(1);
         active <= beat != LAST_CH;
      end

   assign aso_valid         = active;
   assign aso_channel       = beat;
   assign aso_data          = active ? 32'($signed(st_buf[beat])) : '0;
   assign aso_startofpacket = active && beat == '0;
   assign aso_endofpacket   = active && beat == LAST_CH;

   always_comb begin
      status = '0;
      status[15:0] = 16'(level);
      status[ST_EMPTY]  = empty;
      status[ST_FULL]   = full;
      status[ST_OVF]    = ovf;
      status[ST_STDROP] = stdrop;
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         ctrl         <= CTRL_RST;
         o_gen_en     <= 1'b0;
         ovf          <= 1'b0;
         stdrop       <= 1'b0;
         und          <= '0;
         avs_readdata <= '0;
      end else begin
         ctrl     <= avs_write && avs_address == ADDR_CTRL ? avs_writedata[1:0] : ctrl;
         o_gen_en <= en && free >= LVL_W'(HEADROOM);
         // a new event in the same cycle as a clear wins
         ovf      <= (i_sample_valid && full && !pop) || (ovf && !(clr_wr && avs_writedata[CLR_OVF]));
         stdrop   <= (last && pending) || (stdrop && !(clr_wr && avs_writedata[CLR_STDROP]));
         // read-clear and a coincident underrun leave the count at one
         und      <= rd_und ? 16'(underrun) : underrun && und != '1 ? und + 16'd1 : und;
         if (avs_read)
            avs_readdata <= avs_address == ADDR_CTRL ? {30'd0, ctrl} :
                            avs_address == ADDR_STATUS ? status :
                            avs_address == ADDR_UNDERRUN ? {16'd0, und} : '0;
      end
endmodule
